// File: rtl/aes_key_expansion.sv
// Iterative AES-128 key schedule: one round key per accepted valid/ready transfer, first key on the edge after start.
// Stalls fully under backpressure; `define AES_KEYEXP_REPLAY_EN adds stored-key replay (forward or reverse).
module aes_key_expansion #(
  parameter int NUM_ROUNDS = 10,
  parameter int IDX_W      = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [127:0]     i_key,
`ifdef AES_KEYEXP_REPLAY_EN
  input  logic             i_replay,
  input  logic             i_reverse,
`endif
  output logic             o_busy,
  output logic             o_rk_valid,
  input  logic             i_rk_ready,
  output logic [127:0]     o_rk,
  output logic [IDX_W-1:0] o_rk_idx,
  output logic             o_done
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ROUNDS);

  typedef enum logic [0:0] {ST_IDLE, ST_EMIT} state_e;

  state_e           state_q, state_d;
  logic [127:0]     key_q, key_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic             xfer;
  logic [127:0]     key_next;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254 in GF(2^8)) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] inv;
    p   = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [IDX_W-1:0] i);
    logic [7:0] r;
    case (int'(i))
      0:       r = 8'h01;
      1:       r = 8'h02;
      2:       r = 8'h04;
      3:       r = 8'h08;
      4:       r = 8'h10;
      5:       r = 8'h20;
      6:       r = 8'h40;
      7:       r = 8'h80;
      8:       r = 8'h1b;
      9:       r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  logic [31:0] rot_w;
  logic [31:0] temp_w;
  logic [31:0] nw0, nw1, nw2, nw3;

  always_comb begin
    rot_w    = {key_q[23:0], key_q[31:24]};
    temp_w   = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])} ^
               {rcon(idx_q), 24'h000000};
    nw0      = key_q[127:96] ^ temp_w;
    nw1      = key_q[95:64] ^ nw0;
    nw2      = key_q[63:32] ^ nw1;
    nw3      = key_q[31:0] ^ nw2;
    key_next = {nw0, nw1, nw2, nw3};
  end

  assign xfer = (state_q == ST_EMIT) && i_rk_ready;

`ifdef AES_KEYEXP_REPLAY_EN
  logic         rep_q, rep_d;
  logic         rev_q, rev_d;
  logic         ok_q, ok_d;
  logic [127:0] rk_mem [0:NUM_ROUNDS];

  always_ff @(posedge i_clk) begin
    if (xfer && !rep_q) rk_mem[idx_q] <= key_q;
  end
`endif

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
`ifdef AES_KEYEXP_REPLAY_EN
    rep_d   = rep_q;
    rev_d   = rev_q;
    ok_d    = ok_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          key_d   = i_key;
          idx_d   = '0;
          state_d = ST_EMIT;
`ifdef AES_KEYEXP_REPLAY_EN
          rep_d   = 1'b0;
          ok_d    = 1'b0;
        end else if (i_replay && ok_q) begin
          rep_d   = 1'b1;
          rev_d   = i_reverse;
          idx_d   = i_reverse ? LAST : '0;
          state_d = ST_EMIT;
`endif
        end
      end
      ST_EMIT: begin
        if (xfer) begin
`ifdef AES_KEYEXP_REPLAY_EN
          if (rep_q) begin
            if ((rev_q && idx_q == '0) || (!rev_q && idx_q == LAST)) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              idx_d = rev_q ? idx_q - 1'b1 : idx_q + 1'b1;
            end
          end else
`endif
          if (idx_q == LAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
`ifdef AES_KEYEXP_REPLAY_EN
            ok_d    = 1'b1;
`endif
          end else begin
            key_d = key_next;
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
`ifdef AES_KEYEXP_REPLAY_EN
      rep_q   <= 1'b0;
      rev_q   <= 1'b0;
      ok_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
`ifdef AES_KEYEXP_REPLAY_EN
      rep_q   <= rep_d;
      rev_q   <= rev_d;
      ok_q    <= ok_d;
`endif
    end
  end

  assign o_busy     = (state_q == ST_EMIT);
  assign o_rk_valid = (state_q == ST_EMIT);
  assign o_rk_idx   = idx_q;
  assign o_done     = done_q;
`ifdef AES_KEYEXP_REPLAY_EN
  assign o_rk       = rep_q ? rk_mem[idx_q] : key_q;
`else
  assign o_rk       = key_q;
`endif

endmodule

// File: tb/tb_aes_key_expansion.sv
// Directed bench for aes_key_expansion: FIPS-197 vectors through a scoreboard queue.
module tb_aes_key_expansion;

  logic         clk;
  logic         rst_n;
  logic         i_start;
  logic [127:0] i_key;
  logic         i_replay;
  logic         i_reverse;
  logic         o_busy;
  logic         o_rk_valid;
  logic         i_rk_ready;
  logic [127:0] o_rk;
  logic [3:0]   o_rk_idx;
  logic         o_done;

  int checks;
  int failures;

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] key;
    logic         chk_key;
  } sb_t;

  sb_t sb[$];
  logic [127:0] appa [0:10];
  logic [127:0] zk1;

  aes_key_expansion #(.NUM_ROUNDS(10), .IDX_W(4)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (i_start),
    .i_key      (i_key),
`ifdef AES_KEYEXP_REPLAY_EN
    .i_replay   (i_replay),
    .i_reverse  (i_reverse),
`endif
    .o_busy     (o_busy),
    .o_rk_valid (o_rk_valid),
    .i_rk_ready (i_rk_ready),
    .o_rk       (o_rk),
    .o_rk_idx   (o_rk_idx),
    .o_done     (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_appa(input bit reverse);
    for (int i = 0; i <= 10; i++) begin
      int j;
      j = reverse ? 10 - i : i;
      sb.push_back('{idx: 4'(j), key: appa[j], chk_key: 1'b1});
    end
  endtask

  task automatic push_zero();
    sb.push_back('{idx: 4'd0, key: 128'h0, chk_key: 1'b1});
    sb.push_back('{idx: 4'd1, key: zk1, chk_key: 1'b1});
    for (int i = 2; i <= 10; i++) sb.push_back('{idx: 4'(i), key: 128'h0, chk_key: 1'b0});
  endtask

  // Runs one cycle per negedge: drive ready, sample outputs, pop on transfer.
  task automatic drain(input bit rnd, input int inj_idx, input int abort_idx,
                       input bit first_chk, output int vcyc);
    bit           stall;
    bit           rdy;
    logic [127:0] prk;
    logic [3:0]   pidx;
    sb_t          e;
    vcyc  = 0;
    stall = 1'b0;
    prk   = '0;
    pidx  = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rdy        = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      i_rk_ready = rdy;
      i_start    = 1'b0;
      i_replay   = 1'b0;
      if (c == 0 && first_chk) begin
        chk("first_valid", 128'(o_rk_valid), 128'd1);
        chk("no_done_at_start", 128'(o_done), 128'd0);
      end
      if (o_done) begin
        chk("busy_after_done", 128'(o_busy), 128'd0);
        chk("sb_empty_at_done", 128'(sb.size()), 128'd0);
        return;
      end
      if (stall) begin
        chk("stall_rk", o_rk, prk);
        chk("stall_idx", 128'(o_rk_idx), 128'(pidx));
      end
      if (abort_idx >= 0 && o_rk_valid && int'(o_rk_idx) == abort_idx) begin
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 128'(o_rk_valid), 128'd0);
        chk("abort_busy", 128'(o_busy), 128'd0);
        chk("abort_rk", o_rk, 128'h0);
        sb.delete();
        return;
      end
      if (inj_idx >= 0 && o_rk_valid && int'(o_rk_idx) == inj_idx) begin
        i_start = 1'b1;
        i_key   = 128'h0;
      end
      if (o_rk_valid) vcyc++;
      stall = o_rk_valid && !rdy;
      prk   = o_rk;
      pidx  = o_rk_idx;
      if (o_rk_valid && rdy) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL unexpected_key observed_idx=%0d expected=none", o_rk_idx);
        end else begin
          e = sb.pop_front();
          chk("rk_idx", 128'(o_rk_idx), 128'(e.idx));
          if (e.chk_key) chk("rk_key", o_rk, e.key);
        end
      end
    end
    checks++;
    failures++;
    $error("FAIL drain_timeout observed=no_done expected=done");
  endtask

  initial begin
    int v;
    appa[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    appa[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    appa[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    appa[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    appa[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    appa[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    appa[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    appa[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    appa[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    appa[9]  = 128'hac7766f319fadc2128d12941575c006e;
    appa[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    zk1      = 128'h62636363626363636263636362636363;
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    i_start    = 1'b0;
    i_key      = '0;
    i_replay   = 1'b0;
    i_reverse  = 1'b0;
    i_rk_ready = 1'b0;

    #2;
    chk("rst_busy", 128'(o_busy), 128'd0);
    chk("rst_valid", 128'(o_rk_valid), 128'd0);
    chk("rst_rk", o_rk, 128'h0);
    chk("rst_idx", 128'(o_rk_idx), 128'd0);
    chk("rst_done", 128'(o_done), 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // App. A key, ready held high: 11 valid cycles then done
    @(negedge clk);
    i_rk_ready = 1'b1;
    push_appa(1'b0);
    i_start = 1'b1;
    i_key   = appa[0];
    drain(1'b0, -1, -1, 1'b1, v);
    chk("valid_cycles", 128'(v), 128'd11);

    // Start on the o_done cycle with the all-zero key
    push_zero();
    i_start = 1'b1;
    i_key   = 128'h0;
    drain(1'b0, -1, -1, 1'b1, v);
    @(negedge clk);
    chk("done_one_cycle", 128'(o_done), 128'd0);
    chk("idle_busy", 128'(o_busy), 128'd0);

    // Random ready
    push_appa(1'b0);
    i_start = 1'b1;
    i_key   = appa[0];
    drain(1'b1, -1, -1, 1'b1, v);

    // Start pulsed mid-schedule is ignored
    @(negedge clk);
    push_appa(1'b0);
    i_start = 1'b1;
    i_key   = appa[0];
    drain(1'b1, 4, -1, 1'b1, v);

    // Reset at idx 6 aborts, no done; then a clean restart
    @(negedge clk);
    push_appa(1'b0);
    i_start = 1'b1;
    i_key   = appa[0];
    drain(1'b0, -1, 6, 1'b1, v);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_hold_done", 128'(o_done), 128'd0);
      chk("rst_hold_valid", 128'(o_rk_valid), 128'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done", 128'(o_done), 128'd0);
    push_appa(1'b0);
    i_start = 1'b1;
    i_key   = appa[0];
    drain(1'b0, -1, -1, 1'b1, v);

`ifdef AES_KEYEXP_REPLAY_EN
    // Reverse replay of the stored schedule
    @(negedge clk);
    push_appa(1'b1);
    i_replay  = 1'b1;
    i_reverse = 1'b1;
    drain(1'b1, -1, -1, 1'b1, v);
    // Replay after reset is ignored
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    i_replay = 1'b1;
    @(negedge clk);
    i_replay = 1'b0;
    chk("replay_ignored_busy", 128'(o_busy), 128'd0);
    @(negedge clk);
    chk("replay_ignored_valid", 128'(o_rk_valid), 128'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
